// File: rtl/scan_data_reg.sv
// scan_data_reg: JTAG-style data register with a capture/shift stage,
// an update (hold) stage, a 1-bit bypass path and a frame-complete flag.
//
// Ports:
//   clk        rising-edge clock
//   reset      async active-low reset
//   capture    parallel load of data into the shift stage
//   shift      serial shift of the active path (LSB out, tdi into MSB)
//   update     copy shift stage to q (ignored in bypass)
//   bypass     select the 1-bit bypass path
//   data       parallel capture value from the core
//   tdi        serial input
//   q          held value presented to the core
//   tdo        serial output (combinational path select)
//   frame_full high once WIDTH shifts have occurred since capture/reset
module scan_data_reg #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             capture,
  input  logic             shift,
  input  logic             update,
  input  logic             bypass,
  input  logic [WIDTH-1:0] data,
  input  logic             tdi,
  output logic [WIDTH-1:0] q,
  output logic             tdo,
  output logic             frame_full
);

  localparam logic [CNT_W-1:0] FULL =
    CNT_W'(WIDTH);

  logic [WIDTH-1:0] sr;
  logic             bp;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr  <= '0;
      q   <= RESET_VAL;
      bp  <= 1'b0;
      cnt <= '0;
    end else if (!bypass) begin
      // q samples the pre-edge sr, so a
      // shift in the same cycle is not seen
      if (update)
        q <= sr;
      if (capture) begin
        sr  <= data;
        cnt <= '0;
      end else if (shift) begin
        sr <= {tdi, sr[WIDTH-1:1]};
        // saturate so frame_full stays up
        if (cnt != FULL)
          cnt <= cnt + CNT_W'(1);
      end
    end else begin
      // sr, cnt and q hold while bypassed
      if (capture)
        bp <= 1'b0;
      else if (shift)
        bp <= tdi;
    end
  end

  assign tdo        = bypass ? bp : sr[0];
  assign frame_full = (cnt == FULL);

endmodule
